seq_decoder: RTL and testbench
==============================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The module SHALL have parameter SEL_W, default 2, meaning the select width (legal range 1..6).
REQ-002 The module SHALL have parameter ACTIVE_LOW, default 0, meaning that 1 inverts every bit of dout.
REQ-003 The module SHALL derive localparam OUT_W = 2**SEL_W, meaning the one-hot output width.
REQ-004 Port clk: input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n: input, 1 bit, reset, asynchronous and active-low.
REQ-006 Port sel_valid: input, 1 bit, a select code is offered.
REQ-007 Port sel_ready: output, 1 bit, the block accepts the offered code this cycle.
REQ-008 Port sel: input, SEL_W bits, the code to decode.
REQ-009 Port dout: output, OUT_W bits, the registered decoded word.
REQ-010 Port dout_valid: output, 1 bit, dout holds an undelivered word.
REQ-011 Port dout_ready: input, 1 bit, the downstream consumer takes dout.
REQ-012 Port scan_start: input, 1 bit, a one-cycle request to start an auto-scan (present only with DEC_SCAN_EN).
REQ-013 Port scan_busy: output, 1 bit, an auto-scan is in progress (present only with DEC_SCAN_EN).

Function
REQ-014 An input transfer SHALL occur when sel_valid && sel_ready are both high at a clock edge.
REQ-015 An output transfer SHALL occur when dout_valid && dout_ready are both high at a clock edge.
REQ-016 When idle, sel_ready SHALL be (!dout_valid || dout_ready), so the output register is a single-entry pipeline stage with no bubble.
REQ-017 On an input transfer, dout SHALL load the one-hot of sel on the same edge, and dout_valid SHALL be set: latency of 1 cycle.
REQ-018 With ACTIVE_LOW=0 the one-hot word SHALL have bit[sel]=1 and all other bits 0; with ACTIVE_LOW=1 it SHALL be bitwise inverted.
REQ-019 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-020 An output transfer with no simultaneous input transfer SHALL clear dout_valid; dout SHALL then return to the idle word (all 0, or all 1 if ACTIVE_LOW).
REQ-021 Simultaneous input and output transfers SHALL replace dout with the new word and keep dout_valid=1.
REQ-022 sel SHALL be ignored when no input transfer occurs; values of sel that are out of range cannot occur, because OUT_W covers every code.

Reset
REQ-023 While rst_n=0: dout SHALL be the idle word, dout_valid=0, and sel_ready=0.
REQ-024 While rst_n=0 with DEC_SCAN_EN: scan_busy=0 and the scan counter SHALL be 0.
REQ-025 Reset asserted mid-transfer or mid-scan SHALL discard all state immediately, with no pending word delivered.
REQ-026 sel_ready SHALL go high on the first edge after rst_n deasserts.

Configuration
REQ-027 The macro DEC_SCAN_EN SHALL compile in the auto-scan FSM, with states IDLE and SCAN.
REQ-028 IDLE -> SCAN SHALL occur on scan_start=1 while in IDLE; the counter SHALL clear to 0, sel_ready SHALL be forced to 0, and scan_busy=1.
REQ-029 In SCAN, the counter value SHALL be the internal select code: a word SHALL be loaded whenever !dout_valid || dout_ready.
REQ-030 In SCAN, the counter SHALL increment on each load.
REQ-031 SCAN -> IDLE SHALL occur after the load of code OUT_W-1, so exactly OUT_W words are produced in ascending order.
REQ-032 scan_start during SCAN SHALL be ignored.
REQ-033 scan_start together with sel_valid in IDLE SHALL give scan priority, and sel SHALL NOT be accepted that cycle.
REQ-034 Without DEC_SCAN_EN, the ports scan_start and scan_busy, the FSM and the counter SHALL be absent, and the behaviour SHALL equal IDLE permanently.

Structure
REQ-035 A package seq_decoder_pkg SHALL hold the FSM state enum (IDLE, SCAN) and the function onehot(code, SEL_W).
REQ-036 A single sub-module dec_scan_ctr SHALL implement the SEL_W-bit scan counter with clear, increment and last flags, instantiated only under DEC_SCAN_EN.

Verification
REQ-037 Reset then SEL_W=2, ACTIVE_LOW=0, sel=2 with valid, dout_ready=1 -> dout=4'b0100 with dout_valid=1 one cycle later.
REQ-038 dout_ready=0 with sel=1 accepted -> dout stays 4'b0010 and sel_ready=0 until dout_ready=1.
REQ-039 Back-to-back sel=0,1,2,3 with dout_ready=1 -> dout=0001,0010,0100,1000 on consecutive cycles with no bubble.
REQ-040 ACTIVE_LOW=1, SEL_W=3, sel=5 -> dout=8'b1101_1111.
REQ-041 With DEC_SCAN_EN, scan_start pulse and dout_ready=1 -> dout walks 0001..1000 over 4 cycles, then scan_busy falls; a second scan_start mid-scan has no effect.
REQ-042 rst_n pulsed low during a scan -> dout=0000, dout_valid=0 and scan_busy=0 asynchronously, and the scan does not resume.

Source files
------------

// File: rtl/seq_decoder_pkg.sv
// Shared types and helpers for the seq_decoder slice.
// Scan FSM states are only used when DEC_SCAN_EN is defined.
package seq_decoder_pkg;

    typedef enum logic {StIdle, StScan} scan_state_e;

    localparam int unsigned MaxSelW = 6;

    // One-hot of code within a 2**sel_w wide word; callers truncate to their width.
    function automatic logic [63:0] onehot(input logic [MaxSelW-1:0] code,
                                           input int unsigned sel_w);
        logic [63:0] word;
        word = '0;
        if (32'(code) < (32'd1 << sel_w)) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/dec_scan_ctr.sv
// SEL_W-bit scan counter for seq_decoder; clear wins over increment.
// Instantiated only when DEC_SCAN_EN is defined.
module dec_scan_ctr #(
    parameter int unsigned SelW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [SelW-1:0] cnt_o,
    output logic            last_o
);

    logic [SelW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;

endmodule

// File: rtl/seq_decoder.sv
// Registered select-to-one-hot decoder with valid/ready on both sides.
// Define DEC_SCAN_EN to add the auto-scan FSM (scan_start/scan_busy ports).
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned OUT_W     = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
`ifdef DEC_SCAN_EN
    ,
    input  logic             scan_start,
    output logic             scan_busy
`endif
);

    logic             live_q;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             load;
    logic [SEL_W-1:0] load_code;
    logic             space;

    assign space = !dout_valid_q || dout_ready;

`ifdef DEC_SCAN_EN
    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] cnt;
    logic             cnt_last, cnt_clr, cnt_inc;

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        sel_ready = 1'b0;
        load      = 1'b0;
        load_code = sel;
        unique case (state_q)
            StIdle: begin
                // A scan request outranks a simultaneous select offer.
                if (scan_start) begin
                    state_d = StScan;
                    cnt_clr = 1'b1;
                end else begin
                    sel_ready = live_q && space;
                    load      = sel_valid && sel_ready;
                end
            end
            StScan: begin
                if (space) begin
                    load      = 1'b1;
                    load_code = cnt;
                    cnt_inc   = 1'b1;
                    if (cnt_last) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    dec_scan_ctr #(
        .SelW (SEL_W)
    ) u_scan_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    assign scan_busy = (state_q == StScan);
`else
    always_comb begin
        sel_ready = live_q && space;
        load      = sel_valid && sel_ready;
        load_code = sel;
    end
`endif

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (load) begin
            dout_d       = OUT_W'(onehot(MaxSelW'(load_code), SEL_W));
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_d       = '0;
            dout_valid_d = 1'b0;
        end
    end

    // live_q keeps sel_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            live_q       <= 1'b1;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q ^ {OUT_W{ACTIVE_LOW}};
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: two instances (SEL_W=2 true-high, SEL_W=3 active-low)
// checked against a transaction-level model; scan checks need DEC_SCAN_EN.
module tb_seq_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sv0 = 0, sr0, dv0, dr0 = 0;
    logic [1:0] sel0 = '0;
    logic [3:0] dout0;
    logic       sv1 = 0, sr1, dv1, dr1 = 0;
    logic [2:0] sel1 = '0;
    logic [7:0] dout1;
`ifdef DEC_SCAN_EN
    logic ss0 = 0, sb0, ss1 = 0, sb1;
`endif

    int total = 0;
    int bad   = 0;

    seq_decoder #(.SEL_W(2), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sv0), .sel_ready(sr0), .sel(sel0),
        .dout(dout0), .dout_valid(dv0), .dout_ready(dr0)
`ifdef DEC_SCAN_EN
        , .scan_start(ss0), .scan_busy(sb0)
`endif
    );

    seq_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sv1), .sel_ready(sr1), .sel(sel1),
        .dout(dout1), .dout_valid(dv1), .dout_ready(dr1)
`ifdef DEC_SCAN_EN
        , .scan_start(ss1), .scan_busy(sb1)
`endif
    );

    // Model: a pending word (or none), remaining scan words, and out-of-reset flag.
    bit live;
    bit have [2];
    int code [2];
    int scan_left [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_dout(input int i);
        logic [31:0] v;
        v = have[i] ? (32'd1 << code[i]) : 32'd0;
        if (i == 1) v = ~v & 32'hFF;
        return v;
    endfunction

    function automatic bit exp_ready(input int i, input bit ss, input bit dr);
        return live && (scan_left[i] == 0) && !ss && (!have[i] || dr);
    endfunction

    function automatic bit ss_of(input int i);
`ifdef DEC_SCAN_EN
        return (i == 0) ? ss0 : ss1;
`else
        return (i < 0);
`endif
    endfunction

    task automatic check_outputs();
        check_eq("d0_dout", 32'(dout0), exp_dout(0));
        check_eq("d0_valid", 32'(dv0), 32'(have[0]));
        check_eq("d0_ready", 32'(sr0), 32'(exp_ready(0, ss_of(0), dr0)));
        check_eq("d1_dout", 32'(dout1), exp_dout(1));
        check_eq("d1_valid", 32'(dv1), 32'(have[1]));
        check_eq("d1_ready", 32'(sr1), 32'(exp_ready(1, ss_of(1), dr1)));
`ifdef DEC_SCAN_EN
        check_eq("d0_busy", 32'(sb0), 32'(scan_left[0] > 0));
        check_eq("d1_busy", 32'(sb1), 32'(scan_left[1] > 0));
`endif
    endtask

    task automatic model_one(input int i, input int n, input bit sv, input int s,
                             input bit dr, input bit ss);
        bit rdy;
        rdy = exp_ready(i, ss, dr);
        if (scan_left[i] > 0) begin
            if (!have[i] || dr) begin
                have[i] = 1;
                code[i] = n - scan_left[i];
                scan_left[i]--;
            end
        end else if (ss) begin
            scan_left[i] = n;
            if (have[i] && dr) have[i] = 0;
        end else if (sv && rdy) begin
            have[i] = 1;
            code[i] = s;
        end else if (have[i] && dr) begin
            have[i] = 0;
        end
    endtask

    task automatic model_edge();
        model_one(0, 4, sv0, int'(sel0), dr0, ss_of(0));
        model_one(1, 8, sv1, int'(sel1), dr1, ss_of(1));
        live = 1;
    endtask

    // Check before the edge, advance the model on it, return just after it.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        sv0 = 0; sv1 = 0; dr0 = 0; dr1 = 0;
`ifdef DEC_SCAN_EN
        ss0 = 0; ss1 = 0;
`endif
    endtask

    task automatic model_reset();
        live = 0;
        for (int i = 0; i < 2; i++) begin
            have[i] = 0;
            scan_left[i] = 0;
        end
    endtask

    // Assert reset mid-cycle, hold it, release on a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_eq("rst_d0_dout", 32'(dout0), 32'h0);
        check_eq("rst_d1_dout", 32'(dout1), 32'hFF);
        check_outputs();
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("rst_d0_dout", 32'(dout0), 32'h0);
        check_eq("rst_d1_dout", 32'(dout1), 32'hFF);
        check_eq("rst_d0_ready", 32'(sr0), 32'h0);
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("first_ready", 32'(sr0), 32'h1);

        // sel=2 accepted, one cycle later dout=0100
        sv0 = 1; sel0 = 2; dr0 = 1;
        step();
        sv0 = 0;
        check_eq("sel2_dout", 32'(dout0), 32'h4);
        check_eq("sel2_valid", 32'(dv0), 32'h1);
        step();

        // Back-pressure holds dout and blocks input
        dr0 = 0; sv0 = 1; sel0 = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            sel0 = 2'(k + 2);
            step();
            check_eq("hold_dout", 32'(dout0), 32'h2);
            check_eq("hold_ready", 32'(sr0), 32'h0);
        end
        sv0 = 0; dr0 = 1;
        step();

        // Back-to-back stream with no bubble
        sv0 = 1; dr0 = 1;
        for (int k = 0; k < 4; k++) begin
            sel0 = 2'(k);
            step();
            check_eq("b2b_dout", 32'(dout0), 32'd1 << k);
        end
        sv0 = 0;
        step();

        // Active-low, SEL_W=3, sel=5
        sv1 = 1; sel1 = 5; dr1 = 0;
        step();
        sv1 = 0;
        check_eq("al_sel5", 32'(dout1), 32'hDF);
        dr1 = 1;
        step();

`ifdef DEC_SCAN_EN
        // Scan walks 0001..1000; a second start mid-scan is ignored
        dr0 = 1; ss0 = 1; sv0 = 1; sel0 = 3;
        step();
        ss0 = 0; sv0 = 0;
        check_eq("scan_busy_on", 32'(sb0), 32'h1);
        for (int k = 0; k < 4; k++) begin
            ss0 = (k == 1);
            step();
            check_eq("scan_dout", 32'(dout0), 32'd1 << k);
        end
        ss0 = 0;
        check_eq("scan_busy_off", 32'(sb0), 32'h0);
        step();

        // Reset mid-scan discards everything
        ss0 = 1;
        step();
        ss0 = 0;
        step();
        do_reset();
        repeat (4) step();
        check_eq("post_rst_busy", 32'(sb0), 32'h0);
        check_eq("post_rst_valid", 32'(dv0), 32'h0);
`endif

        // Randomized traffic on both instances
        for (int c = 0; c < 400; c++) begin
            sv0 = 1'($urandom_range(0, 1));
            sel0 = 2'($urandom);
            dr0 = ($urandom_range(0, 3) != 0);
            sv1 = 1'($urandom_range(0, 1));
            sel1 = 3'($urandom);
            dr1 = ($urandom_range(0, 2) != 0);
`ifdef DEC_SCAN_EN
            ss0 = ($urandom_range(0, 19) == 0);
            ss1 = ($urandom_range(0, 24) == 0);
`endif
            step();
            if (c == 200) do_reset();
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
